pmod_peer_rx: RTL

- Receive side of the two-board Pmod game link.
- Samples the raw parallel signals driven by the peer board and synchronises them into clk.
- Accepts a value only after it has been stable for STABLE_CYCLES cycles.
- Tracks link state (disconnected / linked / peer-in-reset) and presents decoded, validated peer person ID and peer result to the game logic.
- Sits between the Pmod input pins and the game decision logic; transmit side is unchanged.

---
 rtl/pmod_peer_rx.sv | 118 +++++++++++
 1 files changed

// File: rtl/pmod_peer_rx.sv
// pmod_peer_rx: synchronises, debounces and decodes the peer board's Pmod link signals.
// Tracks link state and presents validated peer person ID and result to the game logic.
module pmod_peer_rx #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] peer_person_raw,
    input  logic [1:0] peer_result_raw,
    input  logic       peer_rst_raw,
    input  logic       peer_ready_n_raw,
    input  logic       peer_present_n_raw,
    output logic       link_up,
    output logic       peer_reset_pulse,
    output logic [3:0] peer_person,
    output logic       person_valid,
    output logic       person_err,
    output logic [1:0] peer_result,
    output logic       result_new,
    output logic       result_err
);
    localparam logic [8:0] IDLE = 9'b1_1_0_00_0000;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {DISC, LINKED, PEER_RST} state_t;

    logic [8:0] raw_w, sync1_q, sync2_q, w_prev_q, stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic       link_up_q, link_up_d, pulse_q, pulse_d;
    logic [3:0] person_q, person_d;
    logic       pv_q, pv_d, perr_q, perr_d;
    logic [1:0] result_q, result_d;
    logic       new_q, new_d, rerr_q, rerr_d;

    logic       s_present_n, s_ready_n, s_rst, linked, show, id_ok;
    logic [3:0] id;
    logic [1:0] code;

    assign raw_w = {peer_present_n_raw, peer_ready_n_raw, peer_rst_raw, peer_result_raw, peer_person_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= IDLE;
            sync2_q   <= IDLE;
            w_prev_q  <= IDLE;
            stable_q  <= IDLE;
            cnt_q     <= '0;
            state_q   <= DISC;
            link_up_q <= 1'b0;
            pulse_q   <= 1'b0;
            person_q  <= '0;
            pv_q      <= 1'b0;
            perr_q    <= 1'b0;
            result_q  <= '0;
            new_q     <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            sync1_q   <= raw_w;
            sync2_q   <= sync1_q;
            w_prev_q  <= sync2_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            link_up_q <= link_up_d;
            pulse_q   <= pulse_d;
            person_q  <= person_d;
            pv_q      <= pv_d;
            perr_q    <= perr_d;
            result_q  <= result_d;
            new_q     <= new_d;
            rerr_q    <= rerr_d;
        end
    end

    // Accept the synchronised word only once the counter has saturated on an unchanged value.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != w_prev_q)
            cnt_d = '0;
        else if (cnt_q < CNT_MAX)
            cnt_d = cnt_q + 8'd1;
        else
            stable_d = sync2_q;
    end

    assign s_present_n = stable_q[8];
    assign s_ready_n   = stable_q[7];
    assign s_rst       = stable_q[6];
    assign code        = {stable_q[4], stable_q[5]};
    assign id          = {stable_q[0], stable_q[1], stable_q[2], stable_q[3]};
    assign id_ok       = (id != 4'd0) && (id <= 4'd9);

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        state_d   = s_present_n ? DISC : (s_rst ? PEER_RST : LINKED);
        linked    = (state_d == LINKED);
        show      = linked && !s_ready_n;
        link_up_d = linked;
        pulse_d   = (state_d == PEER_RST) && (state_q != PEER_RST);
        pv_d      = show && id_ok;
        perr_d    = show && !id_ok;
        person_d  = (show && id_ok) ? id : 4'd0;
        result_d  = !linked ? 2'b00 : ((code == 2'b11) ? result_q : code);
        rerr_d    = linked && (code == 2'b11);
        new_d     = (result_q == 2'b00) && (result_d != 2'b00);
    end

    assign link_up          = link_up_q;
    assign peer_reset_pulse = pulse_q;
    assign peer_person      = person_q;
    assign person_valid     = pv_q;
    assign person_err       = perr_q;
    assign peer_result      = result_q;
    assign result_new       = new_q;
    assign result_err       = rerr_q;
endmodule
